eth_rx_frame_filter: RTL and testbench
======================================

// Module: eth_rx_frame_filter
// PURPOSE
//  Sits between the Ethernet MAC RX stream and state_mgr. Parses the 14-byte
//  Ethernet header and accepts only frames addressed to LOCAL_MAC or broadcast
//  that carry ETHERTYPE. Strips the header and forwards payload bytes to
//  state_mgr as a valid/last/user byte stream. Keeps saturating frame counters.
// PARAMETERS
//  LOCAL_MAC    48'h02_00_00_00_00_01  accepted unicast destination address
//  ETHERTYPE    16'h88B5               accepted EtherType (local experimental)
//  MAX_PAYLOAD  1500                   payload bytes forwarded before truncation
// PORTS
//  clk           in   1   125 MHz Ethernet clock; the only clock
//  rst           in   1   asynchronous, active-high reset
//  in_data       in   8   MAC RX byte
//  in_valid      in   1   in_data valid this cycle
//  in_last       in   1   last byte of frame (qualified by in_valid)
//  in_user       in   1   frame error (CRC/PHY), meaningful only with in_last
//  out_data      out  8   payload byte to state_mgr (rx_data)
//  out_valid     out  1   out_data valid (rx_valid)
//  out_last      out  1   last forwarded payload byte (rx_last)
//  out_user      out  1   forwarded frame is bad/truncated; only with out_last (rx_user)
//  frames_ok     out  16  accepted, error-free frames; saturates at 16'hFFFF
//  frames_drop   out  16  filtered/runt/errored frames; saturates at 16'hFFFF
// BEHAVIOUR
//  - No backpressure: the block never stalls the MAC; downstream consumes every out_valid.
//  - Reset: all outputs 0, FSM in HDR, byte counter 0, counters 0. Reset mid-frame
//    discards the frame with no output; the next frame starts clean once reset deasserts.
//  - Outputs are registered: a payload byte arriving at cycle N appears at N+1.
//  - Byte counter hdr_cnt[3:0] counts header bytes 0..13. Bytes 0-5 are compared to
//    LOCAL_MAC (MSB first) and to 48'hFFFF_FFFF_FFFF. Bytes 12-13 are compared to ETHERTYPE.
//  - FSM (in_valid-qualified; an idle cycle holds state):
//    HDR : consume header. in_last before byte 13 -> drop (runt), stay HDR.
//          At byte 13: if dest and type match and !in_last -> PAY; if match and
//          in_last (zero payload) -> drop, HDR; no match -> DROP (in_last -> HDR).
//    PAY : forward byte, incrementing pay_cnt[10:0]. On in_last -> out_last=1,
//          out_user=in_user, HDR; count ok if !in_user, else drop. On the
//          MAX_PAYLOAD-th byte without in_last -> out_last=1, out_user=1, DROP; count drop.
//    DROP: discard until in_last, then HDR.
//  - A frame is counted exactly once, in the cycle its in_last (or truncation) is seen.
//  - Counters and the output stage are independent of in_data when !in_valid;
//    out_valid is a single-cycle pulse per byte.
//  - Back-to-back frames: in_last followed on the next cycle by a new byte 0 is legal.
//    The next frame's byte 0 is parsed as header.
// STRUCTURE
//  - Shared package eth_pkg: ETH_HDR_LEN=14, ETH_BCAST_MAC, the FSM state encoding
//    (HDR/PAY/DROP), and the default EtherType constant. state_mgr imports the same constants.
//  - One sub-module, sat_counter16 (inc, rst -> q), is instantiated twice for the
//    frame counters. The FSM, header compare and output register stay in this module.
// TESTING
//  1. Unicast to LOCAL_MAC, type 88B5, 4-byte payload 11 22 33 44 -> out 11,22,33,44 at
//     in+1 cycles; last on 44; user=0; frames_ok=1.
//  2. Broadcast dest, type 88B5, 46-byte payload, in_user=1 on last -> 46 bytes out, last+user
//     on byte 46; frames_drop=1, frames_ok=0.
//  3. Wrong dest MAC, then wrong type (0800), back-to-back -> no out_valid; frames_drop=2.
//  4. Runt (in_last on byte 9) then exact 14-byte header-only frame -> no output; frames_drop=2;
//     a following good frame is forwarded correctly.
//  5. MAX_PAYLOAD=8 and 12-byte payload -> 8 bytes out, last+user on 8th; remaining 4 ignored;
//     frames_drop=1.
//  6. rst pulsed during payload byte 3 -> outputs 0 immediately, counters 0; next good frame
//     forwarded; in_valid gaps inside frames do not alter the byte stream.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants and types.
// The frame filter and state_mgr both import this package so that the header
// length, broadcast address, accepted EtherType and parser state encoding
// are defined in exactly one place.
package eth_pkg;

   // Ethernet II header: 6 bytes destination, 6 bytes source, 2 bytes EtherType
   localparam int ETH_HDR_LEN = 14;

   // All-ones destination address accepted as broadcast
   localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

   // Default station address used when the filter is not overridden
   localparam logic [47:0] ETH_LOCAL_MAC_DEFAULT = 48'h02_00_00_00_00_01;

   // Local experimental EtherType carried by our own traffic
   localparam logic [15:0] ETH_TYPE_DEFAULT = 16'h88B5;

   // Largest payload forwarded before a frame is cut short
   localparam int ETH_MAX_PAYLOAD_DEFAULT = 1500;

   // Receive parser states: header parse, payload forward, discard to end of frame
   typedef enum logic [1:0] {
      RX_HDR  = 2'd0,
      RX_PAY  = 2'd1,
      RX_DROP = 2'd2
   } rx_state_e;

   // Returns byte idx of a MAC address in wire order (idx 0 is the most significant byte)
   function automatic logic [7:0] macByte(input logic [47:0] mac, input logic [2:0] idx);
      logic [47:0] shifted;
      shifted = mac << {idx, 3'b000};
      return shifted[47:40];
   endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
// Used for the accepted/dropped frame statistics so that software reading
// a full counter knows it overflowed rather than seeing a small value.
module sat_counter16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] q
);

   logic [15:0] count_q;

   // Count one event per cycle that inc is high, holding once the top value is reached
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 16'h0000;
      end else if (inc && (count_q != 16'hFFFF)) begin
         count_q <= count_q + 16'h0001;
      end
   end

   assign q = count_q;

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Ethernet receive frame filter.
// Parses the 14-byte header of every frame from the MAC, keeps frames sent to
// our station address or to broadcast that carry our EtherType, strips the
// header and passes the payload on as a registered valid/last/user byte stream.
// Every frame is counted exactly once as either accepted or dropped.
// The MAC cannot be stalled, so every decision is made in the cycle the byte arrives.
module eth_rx_frame_filter
   import eth_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC   = ETH_LOCAL_MAC_DEFAULT,
   parameter logic [15:0] ETHERTYPE   = ETH_TYPE_DEFAULT,
   parameter int          MAX_PAYLOAD = ETH_MAX_PAYLOAD_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   input  logic        in_user,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_last,
   output logic        out_user,
   output logic [15:0] frames_ok,
   output logic [15:0] frames_drop
);

   localparam logic [3:0]  HDR_LAST_IDX  = 4'(ETH_HDR_LEN - 1);
   localparam logic [3:0]  DEST_LAST_IDX = 4'd5;
   localparam logic [3:0]  TYPE_HI_IDX   = 4'(ETH_HDR_LEN - 2);
   localparam logic [10:0] PAY_LAST_IDX  = 11'(MAX_PAYLOAD - 1);

   rx_state_e   state_q, state_d;
   logic [3:0]  hdrCnt_q, hdrCnt_d;
   logic [10:0] payCnt_q, payCnt_d;
   logic        ucastHit_q, ucastHit_d;
   logic        bcastHit_q, bcastHit_d;
   logic        typeHi_q, typeHi_d;
   logic        truncated_q, truncated_d;

   logic [7:0]  outData_q, outData_d;
   logic        outValid_q, outValid_d;
   logic        outLast_q, outLast_d;
   logic        outUser_q, outUser_d;

   logic        incOk;
   logic        incDrop;
   logic        typeMatch;
   logic        destMatch;

   // The low EtherType byte is judged against the byte on the wire at header
   // byte 13; the destination verdict was collected over bytes 0..5.
   assign typeMatch = typeHi_q && (in_data == ETHERTYPE[7:0]);
   assign destMatch = ucastHit_q || bcastHit_q;

   // Parser state, header bookkeeping and output stage registers.
   // Asynchronous reset throws away any frame in flight and clears the outputs at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RX_HDR;
         hdrCnt_q    <= 4'd0;
         payCnt_q    <= 11'd0;
         ucastHit_q  <= 1'b0;
         bcastHit_q  <= 1'b0;
         typeHi_q    <= 1'b0;
         truncated_q <= 1'b0;
         outData_q   <= 8'h00;
         outValid_q  <= 1'b0;
         outLast_q   <= 1'b0;
         outUser_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdrCnt_q    <= hdrCnt_d;
         payCnt_q    <= payCnt_d;
         ucastHit_q  <= ucastHit_d;
         bcastHit_q  <= bcastHit_d;
         typeHi_q    <= typeHi_d;
         truncated_q <= truncated_d;
         outData_q   <= outData_d;
         outValid_q  <= outValid_d;
         outLast_q   <= outLast_d;
         outUser_q   <= outUser_d;
      end
   end

   // Next-state and output decode. Only cycles with in_valid move anything:
   // an idle cycle holds all state, produces no output byte and counts nothing,
   // whatever in_data/in_last/in_user happen to carry.
   // The destination match restarts at header byte 0 so back-to-back frames
   // never inherit a verdict from the previous header. A frame that is cut
   // short in payload is counted at the cut, and the truncated flag stops the
   // DROP state from counting it a second time when its in_last finally arrives.
   always_comb begin
      state_d     = state_q;
      hdrCnt_d    = hdrCnt_q;
      payCnt_d    = payCnt_q;
      ucastHit_d  = ucastHit_q;
      bcastHit_d  = bcastHit_q;
      typeHi_d    = typeHi_q;
      truncated_d = truncated_q;
      outData_d   = 8'h00;
      outValid_d  = 1'b0;
      outLast_d   = 1'b0;
      outUser_d   = 1'b0;
      incOk       = 1'b0;
      incDrop     = 1'b0;

      if (in_valid) begin
         unique case (state_q)
            RX_HDR: begin
               if (hdrCnt_q <= DEST_LAST_IDX) begin
                  ucastHit_d = ((hdrCnt_q == 4'd0) || ucastHit_q) &&
                               (in_data == macByte(LOCAL_MAC, hdrCnt_q[2:0]));
                  bcastHit_d = ((hdrCnt_q == 4'd0) || bcastHit_q) &&
                               (in_data == macByte(ETH_BCAST_MAC, hdrCnt_q[2:0]));
               end
               if (hdrCnt_q == TYPE_HI_IDX) begin
                  typeHi_d = (in_data == ETHERTYPE[15:8]);
               end
               if (hdrCnt_q == HDR_LAST_IDX) begin
                  hdrCnt_d = 4'd0;
                  if (in_last) begin
                     incDrop = 1'b1;
                  end else if (destMatch && typeMatch) begin
                     state_d  = RX_PAY;
                     payCnt_d = 11'd0;
                  end else begin
                     state_d     = RX_DROP;
                     truncated_d = 1'b0;
                  end
               end else if (in_last) begin
                  hdrCnt_d = 4'd0;
                  incDrop  = 1'b1;
               end else begin
                  hdrCnt_d = hdrCnt_q + 4'd1;
               end
            end

            RX_PAY: begin
               outValid_d = 1'b1;
               outData_d  = in_data;
               payCnt_d   = payCnt_q + 11'd1;
               if (in_last) begin
                  outLast_d = 1'b1;
                  outUser_d = in_user;
                  incOk     = !in_user;
                  incDrop   = in_user;
                  state_d   = RX_HDR;
               end else if (payCnt_q == PAY_LAST_IDX) begin
                  outLast_d   = 1'b1;
                  outUser_d   = 1'b1;
                  incDrop     = 1'b1;
                  truncated_d = 1'b1;
                  state_d     = RX_DROP;
               end
            end

            RX_DROP: begin
               if (in_last) begin
                  incDrop     = !truncated_q;
                  truncated_d = 1'b0;
                  state_d     = RX_HDR;
               end
            end

            default: begin
               state_d  = RX_HDR;
               hdrCnt_d = 4'd0;
            end
         endcase
      end
   end

   // Accepted, error-free frames
   sat_counter16 u_okCounter (
      .clk (clk),
      .rst (rst),
      .inc (incOk),
      .q   (frames_ok)
   );

   // Filtered, runt, errored and truncated frames
   sat_counter16 u_dropCounter (
      .clk (clk),
      .rst (rst),
      .inc (incDrop),
      .q   (frames_drop)
   );

   assign out_data  = outData_q;
   assign out_valid = outValid_q;
   assign out_last  = outLast_q;
   assign out_user  = outUser_q;

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Testbench for eth_rx_frame_filter.
// Two filters share one input stream: one with the full 1500-byte payload
// limit and one limited to 8 bytes, so truncation is exercised on the same
// traffic. Expected outputs come from a frame-level model: a frame is
// accepted when it is longer than its header, addressed to us or broadcast and
// carries our EtherType; accepted payload bytes reappear one cycle later.
module tb_eth_rx_frame_filter;

   localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
   localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
   localparam logic [15:0] ETYPE     = 16'h88B5;
   localparam int          MAX_A     = 1500;
   localparam int          MAX_B     = 8;
   localparam int          HDR       = 14;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  inData;
   logic        inValid;
   logic        inLast;
   logic        inUser;

   logic [7:0]  aData, bData;
   logic        aValid, bValid, aLast, bLast, aUser, bUser;
   logic [15:0] aOk, aDrop, bOk, bDrop;

   int errors = 0;
   int checks = 0;
   int expOkA = 0, expDropA = 0, expOkB = 0, expDropB = 0;
   logic [7:0] frm [0:255];

   // 125 MHz clock
   always #4 clk = ~clk;

   eth_rx_frame_filter #(.MAX_PAYLOAD(MAX_A)) dutA (
      .clk(clk), .rst(rst),
      .in_data(inData), .in_valid(inValid), .in_last(inLast), .in_user(inUser),
      .out_data(aData), .out_valid(aValid), .out_last(aLast), .out_user(aUser),
      .frames_ok(aOk), .frames_drop(aDrop)
   );

   eth_rx_frame_filter #(.MAX_PAYLOAD(MAX_B)) dutB (
      .clk(clk), .rst(rst),
      .in_data(inData), .in_valid(inValid), .in_last(inLast), .in_user(inUser),
      .out_data(bData), .out_valid(bValid), .out_last(bLast), .out_user(bUser),
      .frames_ok(bOk), .frames_drop(bDrop)
   );

   // Frame-level acceptance rule on the bytes stored in frm
   function automatic bit frameAccepted(input int len);
      logic [47:0] dest;
      logic [15:0] et;
      if (len <= HDR) return 1'b0;
      dest = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
      et   = {frm[12], frm[13]};
      return ((dest == LOCAL_MAC) || (dest == BCAST_MAC)) && (et == ETYPE);
   endfunction

   function automatic int fwdCount(input int len, input int maxPay);
      if (!frameAccepted(len)) return 0;
      return (len - HDR > maxPay) ? maxPay : len - HDR;
   endfunction

   function automatic bit isTrunc(input int len, input int maxPay);
      return frameAccepted(len) && (len - HDR > maxPay);
   endfunction

   // Expected {valid,last,user,data} one cycle after frame byte i was presented
   function automatic logic [10:0] expectByte(input int i, input int len, input bit user, input int maxPay);
      int n;
      int p;
      logic [10:0] e;
      n = fwdCount(len, maxPay);
      p = i - HDR;
      e = '0;
      if ((i >= HDR) && (p < n)) begin
         e[10]  = 1'b1;
         e[9]   = (p == n - 1);
         e[8]   = e[9] && (isTrunc(len, maxPay) || user);
         e[7:0] = frm[i];
      end
      return e;
   endfunction

   function automatic logic [10:0] obsA();
      return {aValid, aLast, aUser, aValid ? aData : 8'h00};
   endfunction

   function automatic logic [10:0] obsB();
      return {bValid, bLast, bUser, bValid ? bData : 8'h00};
   endfunction

   task automatic checkOutput(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed={v,l,u,d}=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkCounter(input string tag, input logic [15:0] obs, input int exp);
      checks++;
      assert (obs === 16'(exp)) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkCounters(input string tag);
      checkCounter({tag, "_okA"}, aOk, expOkA);
      checkCounter({tag, "_dropA"}, aDrop, expDropA);
      checkCounter({tag, "_okB"}, bOk, expOkB);
      checkCounter({tag, "_dropB"}, bDrop, expDropB);
   endtask

   task automatic idle(input int n);
      inValid = 1'b0;
      inLast  = 1'b0;
      inUser  = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         checkOutput("idleA", obsA(), 11'h000);
         checkOutput("idleB", obsB(), 11'h000);
      end
   endtask

   // Present frame byte i, optionally preceded by an idle cycle carrying junk
   task automatic driveByte(input int i, input int len, input bit user, input bit gaps);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
         inValid = 1'b0;
         inData  = 8'($urandom);
         inLast  = 1'($urandom_range(0, 1));
         inUser  = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         checkOutput($sformatf("gapA[%0d]", i), obsA(), 11'h000);
         checkOutput($sformatf("gapB[%0d]", i), obsB(), 11'h000);
      end
      inValid = 1'b1;
      inData  = frm[i];
      inLast  = (i == len - 1);
      inUser  = (i == len - 1) ? user : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checkOutput($sformatf("byteA[%0d]", i), obsA(), expectByte(i, len, user, MAX_A));
      checkOutput($sformatf("byteB[%0d]", i), obsB(), expectByte(i, len, user, MAX_B));
   endtask

   // Send one whole frame, then update and check the frame counters
   task automatic applyStimulus(input string tag, input int len, input bit user, input bit gaps);
      for (int i = 0; i < len; i++) begin
         driveByte(i, len, user, gaps);
      end
      if (frameAccepted(len) && !isTrunc(len, MAX_A) && !user) expOkA++; else expDropA++;
      if (frameAccepted(len) && !isTrunc(len, MAX_B) && !user) expOkB++; else expDropB++;
      checkCounters(tag);
   endtask

   task automatic buildFrame(input logic [47:0] dest, input logic [15:0] et, input int payLen, output int len);
      for (int i = 0; i < 6; i++) begin
         frm[i]     = dest[47 - 8*i -: 8];
         frm[6 + i] = 8'($urandom);
      end
      frm[12] = et[15:8];
      frm[13] = et[7:0];
      for (int i = 0; i < payLen; i++) begin
         frm[HDR + i] = 8'($urandom);
      end
      len = HDR + payLen;
   endtask

   initial begin
      int len;
      logic [47:0] dest;
      logic [15:0] et;
      int kind;

      rst     = 1'b1;
      inValid = 1'b0;
      inData  = 8'h00;
      inLast  = 1'b0;
      inUser  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetA", obsA(), 11'h000);
      checkOutput("resetB", obsB(), 11'h000);
      checkCounters("reset");
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Unicast, four known payload bytes
      buildFrame(LOCAL_MAC, ETYPE, 4, len);
      frm[14] = 8'h11; frm[15] = 8'h22; frm[16] = 8'h33; frm[17] = 8'h44;
      applyStimulus("t1", len, 1'b0, 1'b0);
      idle(2);

      // Broadcast, 46-byte payload flagged bad on its last byte
      buildFrame(BCAST_MAC, ETYPE, 46, len);
      applyStimulus("t2", len, 1'b1, 1'b0);
      idle(2);

      // Wrong destination then wrong EtherType, back to back
      buildFrame(48'h02_00_00_00_00_02, ETYPE, 10, len);
      applyStimulus("t3a", len, 1'b0, 1'b0);
      buildFrame(LOCAL_MAC, 16'h0800, 10, len);
      applyStimulus("t3b", len, 1'b0, 1'b0);
      idle(2);

      // Runt ending on byte 9, header-only frame, then a good frame with gaps
      buildFrame(LOCAL_MAC, ETYPE, 0, len);
      applyStimulus("t4runt", 10, 1'b0, 1'b0);
      applyStimulus("t4hdr", HDR, 1'b0, 1'b0);
      buildFrame(LOCAL_MAC, ETYPE, 6, len);
      applyStimulus("t4good", len, 1'b0, 1'b1);
      idle(2);

      // 12-byte payload: truncated at 8 in dutB, forwarded whole by dutA
      buildFrame(LOCAL_MAC, ETYPE, 12, len);
      applyStimulus("t5", len, 1'b0, 1'b0);
      buildFrame(BCAST_MAC, ETYPE, 8, len);
      applyStimulus("t5exact", len, 1'b0, 1'b0);
      idle(2);

      // Reset asserted while payload byte 3 is on the bus
      buildFrame(LOCAL_MAC, ETYPE, 10, len);
      for (int i = 0; i < 16; i++) begin
         driveByte(i, len, 1'b0, 1'b0);
      end
      inValid = 1'b1;
      inData  = frm[16];
      inLast  = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      expOkA = 0; expDropA = 0; expOkB = 0; expDropB = 0;
      checkOutput("midRstA", obsA(), 11'h000);
      checkOutput("midRstB", obsB(), 11'h000);
      checkCounters("midRst");
      @(negedge clk);
      inValid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      buildFrame(LOCAL_MAC, ETYPE, 9, len);
      applyStimulus("t6good", len, 1'b0, 1'b1);
      idle(1);

      // Randomized traffic
      for (int f = 0; f < 40; f++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0:       dest = LOCAL_MAC;
            1:       dest = BCAST_MAC;
            2:       dest = LOCAL_MAC ^ (48'h1 << $urandom_range(0, 47));
            default: dest = {16'($urandom), 32'($urandom)};
         endcase
         et = ($urandom_range(0, 3) == 0) ? 16'($urandom) : ETYPE;
         buildFrame(dest, et, $urandom_range(0, 20), len);
         if ($urandom_range(0, 7) == 0) len = $urandom_range(1, HDR);
         applyStimulus($sformatf("rnd%0d", f), len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
